// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory block refill engine.
package imem_pkg;
  localparam int WORD_BITS   = 32;
  localparam int BLOCK_BITS  = 256;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fetch_state_e;

  // Word 0 of a block sits in the most significant slot, matching the cache's word select.
  function automatic int slot_msb(input int words, input int slot);
    return words * WORD_BITS - 1 - WORD_BITS * slot;
  endfunction
endpackage

// File: rtl/imem_block_fetch_if.sv
// Bundles the cache request, instruction-memory and refill-result signals of the fetch engine.
interface imem_block_fetch_if #(parameter int WORDS = 8);
  import imem_pkg::*;

  logic                         req_valid;
  logic [31:0]                  req_addr;
  logic                         req_ready;
  logic                         mem_req;
  logic [31:0]                  mem_addr;
  logic                         mem_ack;
  logic [WORD_BITS-1:0]         mem_rdata;
  logic [WORDS*WORD_BITS-1:0]   blk_data;
  logic [31:0]                  blk_addr;
  logic                         blk_valid;
  logic                         busy;
  logic                         fetch_err;

  modport master (
    input  req_valid, req_addr, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_addr, blk_data, blk_addr, blk_valid, busy, fetch_err
  );

  modport slave (
    output req_valid, req_addr, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_addr, blk_data, blk_addr, blk_valid, busy, fetch_err
  );
endinterface

// File: rtl/imem_block_assembler.sv
// Per-slot staging of fetched words; the whole block is copied to blk_data only on commit.
module imem_block_assembler
  import imem_pkg::*;
#(
  parameter int WORDS = 8
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [WORDS-1:0]           slot_we,
  input  logic [WORD_BITS-1:0]       wr_data,
  input  logic                       commit,
  output logic [WORDS*WORD_BITS-1:0] blk_data
);

  logic [WORD_BITS-1:0]       slot_q [WORDS];
  logic [WORD_BITS-1:0]       slot_d [WORDS];
  logic [WORDS*WORD_BITS-1:0] blk_q, blk_d, staged;

  always_comb begin
    for (int i = 0; i < WORDS; i++) begin
      slot_d[i] = slot_we[i] ? wr_data : slot_q[i];
    end
  end

  // The commit cycle also carries the last word, so pack from slot_d rather than slot_q.
  always_comb begin
    staged = '0;
    for (int i = 0; i < WORDS; i++) begin
      staged[slot_msb(WORDS, i) -: WORD_BITS] = slot_d[i];
    end
    blk_d = commit ? staged : blk_q;
  end

  always_ff @(posedge CLK) begin
    slot_q <= slot_d;
    if (!RESET) begin
      blk_q <= '0;
    end else begin
      blk_q <= blk_d;
    end
  end

  assign blk_data = blk_q;

endmodule

// File: rtl/imem_block_fetch.sv
// Block refill engine: fetches WORDS sequential words per miss, with per-word ack timeout.
module imem_block_fetch
  import imem_pkg::*;
#(
  parameter int WORDS       = 8,
  parameter int OFFSET_BITS = 5,
  parameter int TIMEOUT     = 255
) (
  input  logic                CLK,
  input  logic                RESET,
  imem_block_fetch_if.master  bus
);

  localparam int CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  fetch_state_e      state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0]       base_q, base_d;
  logic [31:0]       blk_addr_q, blk_addr_d;
  logic              fetch_err_q, fetch_err_d;
  logic              last_word, timed_out, word_ack;
  logic [WORDS-1:0]  slot_we;

  assign last_word = (count_q == CNT_W'(WORDS - 1));
  assign timed_out = (wait_q == WAIT_W'(TIMEOUT - 1));
  assign word_ack  = (state_q == FETCH) && bus.mem_ack;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= IDLE;
      count_q     <= '0;
      wait_q      <= '0;
      base_q      <= '0;
      blk_addr_q  <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wait_q      <= wait_d;
      base_q      <= base_d;
      blk_addr_q  <= blk_addr_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req_valid) state_d = FETCH;
      FETCH: begin
        if (bus.mem_ack) begin
          if (last_word) state_d = DONE;
        end else if (timed_out) begin
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, latched base and error pulse.
  always_comb begin
    count_d     = count_q;
    wait_d      = wait_q;
    base_d      = base_q;
    blk_addr_d  = blk_addr_q;
    fetch_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          base_d  = bus.req_addr & ~((32'd1 << OFFSET_BITS) - 32'd1);
          count_d = '0;
          wait_d  = '0;
        end
      end
      FETCH: begin
        if (bus.mem_ack) begin
          count_d = count_q + 1'b1;
          wait_d  = '0;
          if (last_word) blk_addr_d = base_q;
        end else if (timed_out) begin
          wait_d      = '0;
          fetch_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    slot_we = '0;
    if (word_ack) slot_we[count_q] = 1'b1;
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.busy      = (state_q == FETCH);
    bus.mem_req   = (state_q == FETCH);
    bus.blk_valid = (state_q == DONE);
    bus.mem_addr  = '0;
    if (state_q == FETCH) bus.mem_addr = base_q + 32'({count_q, 2'b00});
  end

  assign bus.blk_addr  = blk_addr_q;
  assign bus.fetch_err = fetch_err_q;

  imem_block_assembler #(.WORDS(WORDS)) u_asm (
    .CLK      (CLK),
    .RESET    (RESET),
    .slot_we  (slot_we),
    .wr_data  (bus.mem_rdata),
    .commit   (word_ack && last_word),
    .blk_data (bus.blk_data)
  );

endmodule

// File: tb/tb_imem_block_fetch.sv
// Self-checking bench for imem_block_fetch: directed scenarios plus random traffic vs. a block-level model.
module tb_imem_block_fetch;
  localparam int TIMEOUT = 255;
  localparam logic [255:0] BLK_A =
    256'h10000000_10000001_10000002_10000003_10000004_10000005_10000006_10000007;
  localparam logic [255:0] BLK_B =
    256'h20000000_20000001_20000002_20000003_20000004_20000005_20000006_20000007;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  imem_block_fetch_if #(.WORDS(8)) bus ();

  imem_block_fetch #(.WORDS(8), .OFFSET_BITS(5), .TIMEOUT(TIMEOUT)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int valid_pulses = 0;
  int err_pulses = 0;

  // Reference model: phase 0 waiting for a request, 1 collecting words, 2 block delivered.
  int          m_phase;
  logic [31:0] m_base;
  int          m_n;
  int          m_wait;
  logic [31:0] m_words [8];
  logic [255:0] m_blk;
  logic [31:0] m_blkaddr;
  logic        m_err;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic rst_n, input logic rv, input logic [31:0] ra,
                            input logic ack, input logic [31:0] rd);
    if (!rst_n) begin
      m_phase = 0; m_base = '0; m_n = 0; m_wait = 0;
      m_blk = '0; m_blkaddr = '0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      case (m_phase)
        0: if (rv) begin
          m_base = ra & 32'hFFFF_FFE0; m_n = 0; m_wait = 0; m_phase = 1;
        end
        1: if (ack) begin
          m_words[m_n] = rd;
          m_n++;
          m_wait = 0;
          if (m_n == 8) begin
            m_blk = '0;
            for (int i = 0; i < 8; i++) m_blk = (m_blk << 32) | 256'(m_words[i]);
            m_blkaddr = m_base;
            m_phase = 2;
          end
        end else begin
          m_wait++;
          if (m_wait == TIMEOUT) begin
            m_phase = 0; m_err = 1'b1;
          end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic check_all();
    chk("req_ready", 256'(bus.req_ready), 256'(m_phase == 0));
    chk("busy",      256'(bus.busy),      256'(m_phase == 1));
    chk("mem_req",   256'(bus.mem_req),   256'(m_phase == 1));
    chk("blk_valid", 256'(bus.blk_valid), 256'(m_phase == 2));
    chk("fetch_err", 256'(bus.fetch_err), 256'(m_err));
    chk("blk_data",  bus.blk_data,        m_blk);
    chk("blk_addr",  256'(bus.blk_addr),  256'(m_blkaddr));
    if (m_phase == 1) chk("mem_addr", 256'(bus.mem_addr), 256'(m_base + 32'(m_n * 4)));
  endtask

  task automatic cyc(input logic rst_n, input logic rv, input logic [31:0] ra,
                     input logic ack, input logic [31:0] rd);
    RESET = rst_n;
    bus.req_valid = rv;
    bus.req_addr  = ra;
    bus.mem_ack   = ack;
    bus.mem_rdata = rd;
    @(posedge CLK);
    model_step(rst_n, rv, ra, ack, rd);
    #1;
    if (bus.blk_valid) valid_pulses++;
    if (bus.fetch_err) err_pulses++;
    check_all();
  endtask

  initial begin
    int vp0, ep0, n, gap;
    RESET = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_req_ready", 256'(bus.req_ready), 256'd1);
    chk("rst_busy",      256'(bus.busy),      256'd0);
    chk("rst_mem_req",   256'(bus.mem_req),   256'd0);
    chk("rst_mem_addr",  256'(bus.mem_addr),  256'd0);
    chk("rst_blk_valid", 256'(bus.blk_valid), 256'd0);
    chk("rst_fetch_err", 256'(bus.fetch_err), 256'd0);
    chk("rst_blk_data",  bus.blk_data,        256'd0);
    chk("rst_blk_addr",  256'(bus.blk_addr),  256'd0);

    // Back-to-back acks: minimum latency.
    cyc(1, 1, 32'h0040_1234, 0, 0);
    for (int i = 0; i < 8; i++) begin
      chk("t1_mem_addr", 256'(bus.mem_addr), 256'(32'h0040_1220 + 32'(i * 4)));
      cyc(1, 0, 0, 1, 32'h1000_0000 + 32'(i));
    end
    chk("t1_blk_valid", 256'(bus.blk_valid), 256'd1);
    chk("t1_blk_addr",  256'(bus.blk_addr),  256'(32'h0040_1220));
    chk("t1_blk_data",  bus.blk_data,        BLK_A);
    cyc(1, 0, 0, 0, 0);
    chk("t1_ready_again", 256'(bus.req_ready), 256'd1);

    // Random ack gaps.
    vp0 = valid_pulses;
    cyc(1, 1, 32'h0040_1234, 0, 0);
    for (int i = 0; i < 8; i++) begin
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) cyc(1, 0, 0, 0, $urandom);
      cyc(1, 0, 0, 1, 32'h1000_0000 + 32'(i));
    end
    chk("t2_blk_data", bus.blk_data, BLK_A);
    cyc(1, 0, 0, 0, 0);
    chk("t2_one_pulse", 256'(valid_pulses - vp0), 256'd1);

    // Request held through FETCH and DONE.
    cyc(1, 1, 32'h0000_8004, 0, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) chk("t3_old_block_kept", bus.blk_data, BLK_A);
      cyc(1, 1, 32'h0000_8004, 1, 32'h2000_0000 + 32'(i));
    end
    chk("t3_done_not_ready", 256'(bus.req_ready), 256'd0);
    cyc(1, 1, 32'h0000_8004, 1, 32'hDEAD_BEEF);
    chk("t3_idle_ready", 256'(bus.req_ready), 256'd1);
    cyc(1, 1, 32'h0000_8004, 0, 0);
    chk("t3_second_busy", 256'(bus.busy), 256'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t3_block_b_kept", bus.blk_data, BLK_B);
      cyc(1, 0, 0, 1, 32'h3000_0000 + 32'(i));
    end
    chk("t3_second_valid", 256'(bus.blk_valid), 256'd1);
    cyc(1, 0, 0, 0, 0);

    // Timeout on word 3.
    vp0 = valid_pulses; ep0 = err_pulses; n = 0;
    cyc(1, 1, 32'h0001_0040, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, $urandom);
    for (int k = 0; k < 300; k++) begin
      cyc(1, 0, 0, 0, 0);
      if (bus.fetch_err) begin
        n = k + 1;
        break;
      end
    end
    chk("t4_timeout_cycles", 256'(n), 256'(TIMEOUT));
    chk("t4_ready_after_err", 256'(bus.req_ready), 256'd1);
    cyc(1, 0, 0, 0, 0);
    chk("t4_one_err", 256'(err_pulses - ep0), 256'd1);
    chk("t4_no_valid", 256'(valid_pulses - vp0), 256'd0);

    // Reset after word 5 acked, then a clean fetch.
    vp0 = valid_pulses;
    cyc(1, 1, 32'h0000_2000, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1, $urandom);
    cyc(0, 0, 0, 1, $urandom);
    chk("t5_ready", 256'(bus.req_ready), 256'd1);
    chk("t5_mem_req", 256'(bus.mem_req), 256'd0);
    chk("t5_busy", 256'(bus.busy), 256'd0);
    chk("t5_blk_data", bus.blk_data, 256'd0);
    chk("t5_no_valid", 256'(valid_pulses - vp0), 256'd0);
    cyc(1, 1, 32'h0040_1234, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1, 32'h1000_0000 + 32'(i));
    chk("t5_refetch", bus.blk_data, BLK_A);
    cyc(1, 0, 0, 0, 0);

    // Stray acks while idle.
    vp0 = valid_pulses;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, $urandom);
    chk("t6_idle_ready", 256'(bus.req_ready), 256'd1);
    chk("t6_idle_busy", 256'(bus.busy), 256'd0);
    chk("t6_no_valid", 256'(valid_pulses - vp0), 256'd0);

    // Random traffic.
    for (int k = 0; k < 500; k++) begin
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) == 0), $urandom,
          ($urandom_range(0, 2) != 0), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
